// File: rtl/iq_decim_pkg.sv
// Shared helpers for the IQ integrate-and-dump decimator: lane count, accumulator sizing, saturation.
// Latency: combinational functions only.
// Backpressure: none; pure functions.
package iq_decim_pkg;

    // Every complex channel occupies two lanes: I at the even index, Q at the odd one.
    function automatic int lane_count(input int nch);
        return 2 * nch;
    endfunction

    // Summing up to 2^rw-1 full-scale samples needs rw extra bits on top of the sample width.
    function automatic int acc_width(input int wd, input int rw);
        return wd + rw;
    endfunction

    // True when x lies outside the signed range of an ow-bit result.
    function automatic logic sat_hit(input logic signed [63:0] x, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        return (x > hi) || (x < lo);
    endfunction

    // Clamp x into the signed range of an ow-bit result; caller truncates to ow bits.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/iq_dump_lane.sv
// One decimator lane: accumulator, arithmetic shift, saturation and sticky overflow bit.
// Latency: dumped result registered one cycle after the dumping sample.
// Backpressure: none; follows the dump/sync decisions made by the shared control.
module iq_dump_lane
    import iq_decim_pkg::*;
#(
    parameter int WIDTH_DATA = 14,
    parameter int OUT_WIDTH  = 16,
    parameter int ACC_WIDTH  = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH_DATA-1:0] sample,
    input  logic                  dump,
    input  logic                  sync,
    input  logic                  seed,
    input  logic [4:0]            shift,
    input  logic                  ovf_clr,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  ovf
);

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [63:0]          wide;
    logic                        hit;
    logic [OUT_WIDTH-1:0]        out_q;
    logic [OUT_WIDTH-1:0]        out_d;
    logic                        ovf_q;
    logic                        ovf_d;

    // Sum including the current sample, scaled and checked against the output range.
    always_comb begin
        sample_ext = ACC_WIDTH'($signed(sample));
        sum        = acc_q + sample_ext;
        shifted    = sum >>> shift;
        wide       = 64'(shifted);
        hit        = sat_hit(wide, OUT_WIDTH);
    end

    // Next-state: sync restarts (optionally seeded with this sample), dump emits and empties, valid accumulates.
    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        ovf_d = ovf_q & ~ovf_clr;
        if (sync) begin
            acc_d = seed ? sample_ext : '0;
        end else if (dump) begin
            acc_d = '0;
            out_d = OUT_WIDTH'(sat_clip(wide, OUT_WIDTH));
            ovf_d = ovf_d | hit;
        end else if (in_valid) begin
            acc_d = sum;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_data = out_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/iq_dump_decim.sv
// Integrate-and-dump decimator over 2*NCH I/Q lanes with shift, saturation and sticky overflow.
// Latency: out_valid/out_data registered one cycle after the dumping in_valid sample.
// Backpressure: none; in_valid is a strobe and out_valid a one-cycle pulse.
module iq_dump_decim
    import iq_decim_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int WIDTH_DATA  = 14,
    parameter int RATIO_WIDTH = 8,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [2*NCH*WIDTH_DATA-1:0]     in_data,
    input  logic [RATIO_WIDTH-1:0]          ratio,
    input  logic [4:0]                      shift,
    input  logic                            sync,
    input  logic                            ovf_clr,
    output logic                            out_valid,
    output logic [2*NCH*OUT_WIDTH-1:0]      out_data,
    output logic [2*NCH-1:0]                ovf
);

    localparam int LANES     = lane_count(NCH);
    localparam int ACC_WIDTH = acc_width(WIDTH_DATA, RATIO_WIDTH);

    logic [RATIO_WIDTH-1:0] ratio_l_q;
    logic [RATIO_WIDTH-1:0] ratio_l_d;
    logic [RATIO_WIDTH-1:0] cnt_q;
    logic [RATIO_WIDTH-1:0] cnt_d;
    logic                   out_valid_q;
    logic                   out_valid_d;
    logic [RATIO_WIDTH-1:0] last;
    logic                   dump;
    logic                   seed;

    // Terminal count of the current period; ratios of 0 and 1 both mean pass-through.
    always_comb begin
        last = (ratio_l_q <= RATIO_WIDTH'(1)) ? '0 : ratio_l_q - RATIO_WIDTH'(1);
        dump = in_valid & ~sync & (cnt_q == last);
        // A sync-cycle sample opens the new period only when that period is longer than one sample.
        seed = in_valid & (ratio > RATIO_WIDTH'(1));
    end

    // Shared period counter and ratio latch; sync overrides any dump on the same cycle.
    always_comb begin
        ratio_l_d   = ratio_l_q;
        cnt_d       = cnt_q;
        out_valid_d = dump;
        if (sync) begin
            ratio_l_d = ratio;
            cnt_d     = seed ? RATIO_WIDTH'(1) : '0;
        end else if (dump) begin
            ratio_l_d = ratio;
            cnt_d     = '0;
        end else if (in_valid) begin
            cnt_d = cnt_q + RATIO_WIDTH'(1);
        end
    end

    // Control registers; the ratio port is tracked throughout reset so release starts with it latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_l_q   <= ratio;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ratio_l_q   <= ratio_l_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        iq_dump_lane #(
            .WIDTH_DATA (WIDTH_DATA),
            .OUT_WIDTH  (OUT_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .sample   (in_data[k*WIDTH_DATA +: WIDTH_DATA]),
            .dump     (dump),
            .sync     (sync),
            .seed     (seed),
            .shift    (shift),
            .ovf_clr  (ovf_clr),
            .out_data (out_data[k*OUT_WIDTH +: OUT_WIDTH]),
            .ovf      (ovf[k])
        );
    end

endmodule

// File: tb/tb_iq_dump_decim.sv
// Bench for iq_dump_decim: directed scenarios plus a random phase against a sample-list reference model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_iq_dump_decim;

    localparam int NCH = 2;
    localparam int WD  = 14;
    localparam int RW  = 8;
    localparam int OW  = 16;
    localparam int L   = 2 * NCH;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [L*WD-1:0]   in_data;
    logic [RW-1:0]     ratio;
    logic [4:0]        shift;
    logic              sync;
    logic              ovf_clr;
    logic              out_valid;
    logic [L*OW-1:0]   out_data;
    logic [L-1:0]      ovf;

    int errs   = 0;
    int checks = 0;

    // Reference model state: samples gathered in the current period and the period length.
    int              m_n;
    int              m_rl;
    longint          m_sum [L];
    logic [L*OW-1:0] e_data;
    logic            e_valid;
    logic [L-1:0]    e_ovf;

    iq_dump_decim #(
        .NCH         (NCH),
        .WIDTH_DATA  (WD),
        .RATIO_WIDTH (RW),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ratio     (ratio),
        .shift     (shift),
        .sync      (sync),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int eff(input logic [RW-1:0] r);
        return (r <= 1) ? 1 : int'(r);
    endfunction

    function automatic longint smp(input int k);
        logic signed [WD-1:0] s;
        s = in_data[k*WD +: WD];
        return longint'(s);
    endfunction

    function automatic longint lane_out(input int k);
        logic signed [OW-1:0] s;
        s = out_data[k*OW +: OW];
        return longint'(s);
    endfunction

    task automatic set_lane(input int k, input int v);
        in_data[k*WD +: WD] = WD'(v);
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < L; k++) set_lane(k, v);
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: applies the current inputs as one clock edge of the decimator.
    task automatic model_step();
        longint v;
        if (reset) begin
            m_n = 0;
            for (int k = 0; k < L; k++) m_sum[k] = 0;
            e_data  = '0;
            e_valid = 1'b0;
            e_ovf   = '0;
            m_rl    = eff(ratio);
            return;
        end
        e_valid = 1'b0;
        if (ovf_clr) e_ovf = '0;
        if (sync) begin
            m_rl = eff(ratio);
            m_n  = 0;
            for (int k = 0; k < L; k++) m_sum[k] = 0;
            if (in_valid && m_rl > 1) begin
                for (int k = 0; k < L; k++) m_sum[k] = smp(k);
                m_n = 1;
            end
            return;
        end
        if (!in_valid) return;
        for (int k = 0; k < L; k++) m_sum[k] += smp(k);
        m_n++;
        if (m_n == m_rl) begin
            for (int k = 0; k < L; k++) begin
                v = m_sum[k] >>> shift;
                if (v > 32767) begin
                    v = 32767;
                    e_ovf[k] = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    e_ovf[k] = 1'b1;
                end
                e_data[k*OW +: OW] = OW'(v);
                m_sum[k] = 0;
            end
            e_valid = 1'b1;
            m_n     = 0;
            m_rl    = eff(ratio);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", longint'(out_valid), longint'(e_valid));
        chk("out_data", longint'(out_data), longint'(e_data));
        chk("ovf", longint'(ovf), longint'(e_ovf));
    endtask

    initial begin
        int first;
        int nv;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ratio    = 8'd4;
        shift    = 5'd0;
        sync     = 1'b0;
        ovf_clr  = 1'b0;
        m_n = 0; m_rl = 1; e_data = '0; e_valid = 1'b0; e_ovf = '0;
        for (int k = 0; k < L; k++) m_sum[k] = 0;

        // Reset state
        set_all(100);
        repeat (3) tick();
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_data", longint'(out_data), 0);
        chk("rst_ovf", longint'(ovf), 0);

        // Ratio 4, constant 100: a 400 every 4th sample
        reset    = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i % 4 == 0) begin
                chk("r4_valid", longint'(out_valid), 1);
                chk("r4_lane0", lane_out(0), 400);
                chk("r4_lane3", lane_out(3), 400);
            end else begin
                chk("r4_quiet", longint'(out_valid), 0);
            end
        end
        chk("r4_ovf", longint'(ovf), 0);

        // Ratio 1 ramp: output is the input one cycle later
        in_valid = 1'b0; sync = 1'b1; ratio = 8'd1;
        tick();
        sync = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < L; k++) set_lane(k, i * 10 - 30 + k);
            tick();
            chk("r1_valid", longint'(out_valid), 1);
            chk("r1_lane0", lane_out(0), longint'(i * 10 - 30));
        end

        // Ratio 255 full-scale on lane 0 saturates only lane 0
        in_valid = 1'b0; sync = 1'b1; ratio = 8'd255;
        tick();
        sync = 1'b0; in_valid = 1'b1;
        set_lane(0, 8191);
        for (int i = 0; i < 255; i++) begin
            for (int k = 1; k < L; k++) set_lane(k, int'($urandom_range(0, 200)) - 100);
            tick();
        end
        chk("sat_valid", longint'(out_valid), 1);
        chk("sat_lane0", lane_out(0), 32767);
        chk("sat_ovf", longint'(ovf), 1);
        in_valid = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", longint'(ovf), 0);

        // Ratio 8 with sparse valids; ratio change to 2 mid-period applies next period
        sync = 1'b1; ratio = 8'd8;
        tick();
        sync = 1'b0;
        first = -1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c % 2 == 0);
            for (int k = 0; k < L; k++) set_lane(k, int'($urandom_range(0, 2000)) - 1000);
            if (c == 6) ratio = 8'd2;
            tick();
            if (out_valid && first < 0) first = c;
        end
        chk("r8_first_dump_cycle", longint'(first), 14);
        nv = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < L; k++) set_lane(k, int'($urandom_range(0, 2000)) - 1000);
            tick();
            if (out_valid) nv++;
        end
        chk("r2_dumps_in_4", longint'(nv), 2);

        // Sync on the would-be dump, with a -50 sample that seeds the new period
        in_valid = 1'b0; sync = 1'b1; ratio = 8'd4;
        tick();
        sync = 1'b0; in_valid = 1'b1; set_all(10);
        repeat (3) tick();
        set_all(-50); sync = 1'b1;
        tick();
        chk("sync_no_out", longint'(out_valid), 0);
        sync = 1'b0; set_all(10);
        repeat (3) tick();
        chk("sync_next_valid", longint'(out_valid), 1);
        chk("sync_next_lane0", lane_out(0), -20);

        // Reset on the dumping cycle, then floor shift of negative sum
        in_valid = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_all(int'($urandom_range(0, 400)) - 200);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("rst_dump_valid", longint'(out_valid), 0);
        chk("rst_dump_data", longint'(out_data), 0);
        reset = 1'b0; shift = 5'd2; set_all(-7);
        repeat (4) tick();
        chk("floor_valid", longint'(out_valid), 1);
        chk("floor_lane0", lane_out(0), -7);
        chk("floor_lane2", lane_out(2), -7);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < L; k++) in_data[k*WD +: WD] = WD'($urandom_range(0, 16383));
            if ($urandom_range(0, 9) == 0) ratio = RW'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) shift = 5'($urandom_range(0, 31));
            sync    = ($urandom_range(0, 19) == 0);
            ovf_clr = ($urandom_range(0, 14) == 0);
            tick();
        end
        sync = 1'b0; ovf_clr = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
